// File: rtl/tp_pkg.sv
// Shared types and constants for the time-of-day core: state encoding, field moduli
// and the binary-to-BCD helper used by the display path.
package tp_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_S  = 3'd3,
        SET_AH = 3'd4,
        SET_AM = 3'd5
    } state_t;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    // Two BCD digits {tens, ones} of a 0..63 value.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/timekeeper_core_if.sv
// Button/tick inputs and display-side outputs of the time-of-day core.
// slave = the core, master = whoever drives the buttons and reads the time.
interface timekeeper_core_if;

    logic              tick_1hz;
    logic              mode_button;
    logic              add_button;
    logic              sub_button;
    logic [4:0]        hours;
    logic [5:0]        minutes;
    logic [5:0]        seconds;
    logic [23:0]       bcd_digits;
    tp_pkg::state_t    state_o;
    logic              day_wrap;
    logic              alarm;

    modport slave (
        input  tick_1hz, mode_button, add_button, sub_button,
        output hours, minutes, seconds, bcd_digits, state_o, day_wrap, alarm
    );

    modport master (
        output tick_1hz, mode_button, add_button, sub_button,
        input  hours, minutes, seconds, bcd_digits, state_o, day_wrap, alarm
    );

endinterface

// File: rtl/timekeeper_core_mod_counter.sv
// Modulo-MOD up/down counter for one time field; carry flags the increment wrap
// so the caller can cascade it into the next field in the same cycle.
module mod_counter #(
    parameter int W   = 6,
    parameter int MOD = 60
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic [W-1:0] value_reg;
    logic [W-1:0] value_next;

    // inc and dec together cancel out
    always_comb begin
        value_next = value_reg;
        if (clr)
            value_next = '0;
        else if (inc && !dec)
            value_next = (value_reg == MAX) ? '0 : value_reg + 1'b1;
        else if (dec && !inc)
            value_next = (value_reg == '0) ? MAX : value_reg - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            value_reg <= '0;
        else
            value_reg <= value_next;
    end

    assign value = value_reg;
    assign carry = inc && !dec && !clr && (value_reg == MAX);

endmodule

// File: rtl/timekeeper_core.sv
// HH:MM:SS time-of-day core with button-driven set mode and BCD display output.
// Define TIMEKEEPER_ALARM_EN to add the alarm registers, alarm set states and alarm flag.
module timekeeper_core
    import tp_pkg::*;
#(
    parameter int HOUR_MODULO = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    timekeeper_core_if.slave    bus
);

    logic [2:0] raw;
    logic [2:0] pulse;
    logic       mode_p, add_p, sub_p;

    assign raw = {bus.sub_button, bus.add_button, bus.mode_button};

    // Synchroniser chain, then a registered rising-edge detector per button.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   pulse_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_reg  <= '0;
                    prev_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
                    prev_reg  <= sync_reg[SYNC_STAGES-1];
                    pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
                end
            end

            assign pulse[gi] = pulse_reg;
        end
    endgenerate

    assign mode_p = pulse[0];
    assign add_p  = pulse[1];
    assign sub_p  = pulse[2];

    state_t state_reg, state_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (mode_p) begin
            case (state_reg)
                RUN:     state_next = SET_H;
                SET_H:   state_next = SET_M;
                SET_M:   state_next = SET_S;
`ifdef TIMEKEEPER_ALARM_EN
                SET_S:   state_next = SET_AH;
                SET_AH:  state_next = SET_AM;
                SET_AM:  state_next = RUN;
`else
                SET_S:   state_next = RUN;
`endif
                default: state_next = RUN;
            endcase
        end
    end

    logic run, run_tick, edit_add, edit_sub;
    logic sel_h, sel_m, sel_s;
    logic sec_inc, sec_dec, sec_carry;
    logic min_inc, min_dec, min_carry;
    logic hr_inc, hr_dec, hr_carry;

    assign run      = (state_reg == RUN);
    assign run_tick = run & bus.tick_1hz;
    assign sel_h    = (state_reg == SET_H);
    assign sel_m    = (state_reg == SET_M);
    assign sel_s    = (state_reg == SET_S);
    // mode wins over add/sub; add and sub together do nothing
    assign edit_add = add_p & ~sub_p & ~mode_p;
    assign edit_sub = sub_p & ~add_p & ~mode_p;

    // Carries only cascade while running; edits never ripple into other fields.
    assign sec_inc = run_tick | (sel_s & edit_add);
    assign sec_dec = sel_s & edit_sub;
    assign min_inc = (run_tick & sec_carry) | (sel_m & edit_add);
    assign min_dec = sel_m & edit_sub;
    assign hr_inc  = (run & min_carry) | (sel_h & edit_add);
    assign hr_dec  = sel_h & edit_sub;

    mod_counter #(.W(6), .MOD(SEC_MOD)) u_sec (
        .clock(clock), .reset(reset), .inc(sec_inc), .dec(sec_dec), .clr(1'b0),
        .value(bus.seconds), .carry(sec_carry)
    );

    mod_counter #(.W(6), .MOD(MIN_MOD)) u_min (
        .clock(clock), .reset(reset), .inc(min_inc), .dec(min_dec), .clr(1'b0),
        .value(bus.minutes), .carry(min_carry)
    );

    mod_counter #(.W(5), .MOD(HOUR_MODULO)) u_hr (
        .clock(clock), .reset(reset), .inc(hr_inc), .dec(hr_dec), .clr(1'b0),
        .value(bus.hours), .carry(hr_carry)
    );

    logic        day_wrap_reg;
    logic [23:0] bcd_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            day_wrap_reg <= 1'b0;
            bcd_reg      <= '0;
        end else begin
            day_wrap_reg <= run & hr_carry;
            bcd_reg      <= {to_bcd({1'b0, bus.hours}), to_bcd(bus.minutes), to_bcd(bus.seconds)};
        end
    end

    assign bus.day_wrap   = day_wrap_reg;
    assign bus.bcd_digits = bcd_reg;
    assign bus.state_o    = state_reg;

`ifdef TIMEKEEPER_ALARM_EN
    logic [4:0] alarm_h;
    logic [5:0] alarm_m;
    logic       ah_carry, am_carry;
    logic [5:0] minute_after;
    logic [4:0] hour_after;
    logic       alarm_reg;

    mod_counter #(.W(5), .MOD(HOUR_MODULO)) u_alarm_h (
        .clock(clock), .reset(reset),
        .inc((state_reg == SET_AH) & edit_add), .dec((state_reg == SET_AH) & edit_sub),
        .clr(1'b0), .value(alarm_h), .carry(ah_carry)
    );

    mod_counter #(.W(6), .MOD(MIN_MOD)) u_alarm_m (
        .clock(clock), .reset(reset),
        .inc((state_reg == SET_AM) & edit_add), .dec((state_reg == SET_AM) & edit_sub),
        .clr(1'b0), .value(alarm_m), .carry(am_carry)
    );

    // Time the current tick will produce, valid when it rolls seconds over to 0.
    assign minute_after = min_carry ? 6'd0 : bus.minutes + 6'd1;
    assign hour_after   = min_carry ? (hr_carry ? 5'd0 : bus.hours + 5'd1) : bus.hours;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            alarm_reg <= 1'b0;
        else if (|pulse)
            alarm_reg <= 1'b0;
        else if (run_tick && sec_carry && hour_after == alarm_h && minute_after == alarm_m)
            alarm_reg <= 1'b1;
    end

    assign bus.alarm = alarm_reg | (1'b0 & (ah_carry | am_carry));
`else
    assign bus.alarm = 1'b0;
`endif

endmodule
